tt_mux_ctrl: RTL and testbench
==============================

TT_MUX_CTRL -- requirements
Module: tt_mux_ctrl

Interface
REQ-001 Parameter NUM_PROJ, default 4: number of project wrappers sharing the pin set (2..16).
REQ-002 Parameter ADDR_W, default 2: select address width; SHALL equal ceil(log2(NUM_PROJ)).
REQ-003 Parameter RST_CYCLES, default 8: project reset hold length in clk cycles (1..255).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sel_rst  in  1  single-cycle pulse: clear address, deselect all projects.
REQ-007 sel_inc  in  1  single-cycle pulse: advance address, re-reset the newly selected project.
REQ-008 sel_go  in  1  single-cycle pulse: start the currently addressed project from IDLE.
REQ-009 ui_in  in  8  shared dedicated inputs; uio_in  in  8  shared bidir inputs.
REQ-010 proj_clk  in  1  project clock source forwarded on iw bit 0.
REQ-011 ow_bus  in  NUM_PROJ*24  packed per-project {uio_oe, uio_out, uo_out}; project k at bits [24k+23:24k].
REQ-012 iw  out  18  shared project input bus {uio_in, ui_in, rst_n, clk}.
REQ-013 ena  out  NUM_PROJ  one-hot project enable (all-zero when none selected).
REQ-014 ow  out  24  selected project's output word.
REQ-015 addr  out  ADDR_W  current select address; state  out  2  FSM state; busy  out  1  high in RESET.

Function
REQ-016 FSM states: IDLE=0, RESET=1, RUN=2; encoding 3 unused and SHALL return to IDLE next cycle.
REQ-017 IDLE: ena=0, iw=0, ow=0.
REQ-018 IDLE + sel_go -> RESET, counter loaded with RST_CYCLES-1, addr unchanged.
REQ-019 Any state + sel_inc -> RESET; addr = addr+1, wrapping NUM_PROJ-1 -> 0; counter reloaded.
REQ-020 Any state + sel_rst -> IDLE, addr=0; sel_rst SHALL take priority over sel_inc and sel_go in the same cycle.
REQ-021 sel_inc SHALL take priority over sel_go; sel_go outside IDLE SHALL be ignored.
REQ-022 RESET: ena[addr]=1, iw[1]=0, iw[17:2]=0, iw[0]=proj_clk; counter decrements each cycle; at counter 0 -> RUN next cycle, so iw[1] is low for exactly RST_CYCLES cycles.
REQ-023 RUN: ena[addr]=1, iw = {uio_in, ui_in, 1, proj_clk}, combinational from inputs.
REQ-024 ena, iw[1], addr, state, busy SHALL be registered; iw[17:2] and iw[0] are gated combinationally by the registered state.
REQ-025 In RESET and RUN, ow = ow_bus slice at addr; slices of non-selected projects SHALL never reach ow.
REQ-026 ena SHALL never have more than one bit set in any cycle, including the cycle sel_inc changes addr.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, addr=0, counter=0, ena=0, iw[1]=0, ow=0, busy=0, from the next cycle onward.
REQ-028 rst mid-RESET or mid-RUN SHALL abort immediately to IDLE; pulses on sel_* in a cycle with rst=1 are discarded.

Configuration
REQ-029 Macro TT_MUX_CTRL_OWREG_EN: when defined, ow SHALL be registered (one clk of latency from ow_bus/addr, reset value 0, cleared the cycle after entering IDLE); when undefined, ow SHALL be combinational with zero latency.

Verification
REQ-030 rst, then sel_go -> ena=4'b0001 and iw[1]=0 for exactly 8 cycles, then state=RUN, iw[1]=1, iw[17:2]={uio_in,ui_in}.
REQ-031 In RUN addr=3, sel_inc -> addr=0, ena=4'b0001, busy=1, iw[1]=0 for 8 cycles; ena never multi-hot.
REQ-032 sel_rst and sel_inc in the same cycle from RUN addr=2 -> state=IDLE, addr=0, ena=0, ow=0.
REQ-033 RUN addr=2, ow_bus slice 2=24'hA5C33C, others 24'hFFFFFF -> ow=24'hA5C33C (one cycle later with TT_MUX_CTRL_OWREG_EN).
REQ-034 rst asserted 3 cycles into RESET -> next cycle state=IDLE, ena=0, busy=0; later sel_go restarts a full 8-cycle reset.
REQ-035 sel_go while in RUN -> no change to state, addr, ena or counter.

Source files
------------

// File: rtl/tt_mux_ctrl.sv
// Select/reset controller that time-multiplexes one shared pin set across NUM_PROJ project wrappers.
// Optional macro TT_MUX_CTRL_OWREG_EN registers the selected output word (one clk of latency).
module tt_mux_ctrl #(
  parameter int NUM_PROJ   = 4,
  parameter int ADDR_W     = 2,
  parameter int RST_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_rst,
  input  logic                     sel_inc,
  input  logic                     sel_go,
  input  logic [7:0]               ui_in,
  input  logic [7:0]               uio_in,
  input  logic                     proj_clk,
  input  logic [NUM_PROJ*24-1:0]   ow_bus,
  output logic [17:0]              iw,
  output logic [NUM_PROJ-1:0]      ena,
  output logic [23:0]              ow,
  output logic [ADDR_W-1:0]        addr,
  output logic [1:0]               state,
  output logic                     busy
);

  localparam logic [1:0]        S_IDLE    = 2'd0;
  localparam logic [1:0]        S_RESET   = 2'd1;
  localparam logic [1:0]        S_RUN     = 2'd2;
  localparam logic [7:0]        CNT_LOAD  = 8'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PROJ - 1);

  logic [1:0]          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [NUM_PROJ-1:0] r_ena, w_ena_nxt;
  logic                r_rstn, w_rstn_nxt;
  logic                r_busy, w_busy_nxt;
  logic [17:0]         w_iw;
  logic [23:0]         w_ow_sel;
  logic                w_active;

  // State register; the registered outputs are loaded from next-state values so they
  // line up with r_state in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_ena   <= '0;
      r_rstn  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ena   <= w_ena_nxt;
      r_rstn  <= w_rstn_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state: sel_rst overrides sel_inc, which overrides sel_go and the normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (sel_go) begin
          w_state_nxt = S_RESET;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_RESET: begin
        if (r_cnt == 8'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
    if (sel_inc) begin
      w_state_nxt = S_RESET;
      w_addr_nxt  = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
      w_cnt_nxt   = CNT_LOAD;
    end
    if (sel_rst) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
    end
  end

  // Output decode from next state; ena is decoded from a single address so it is one-hot by construction.
  always_comb begin
    w_ena_nxt  = '0;
    w_rstn_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt = (w_state_nxt == S_RESET);
    if (w_state_nxt == S_RESET || w_state_nxt == S_RUN) begin
      for (int k = 0; k < NUM_PROJ; k++) begin
        if (w_addr_nxt == ADDR_W'(k)) w_ena_nxt[k] = 1'b1;
      end
    end
  end

  assign w_active = (r_state == S_RESET) || (r_state == S_RUN);

  // Shared buses gated by the registered state; only the addressed slice is ever muxed to ow.
  always_comb begin
    w_iw     = '0;
    w_ow_sel = '0;
    w_iw[1]  = r_rstn;
    if (w_active) begin
      w_iw[0] = proj_clk;
      for (int k = 0; k < NUM_PROJ; k++) begin
        if (r_addr == ADDR_W'(k)) w_ow_sel = ow_bus[24*k +: 24];
      end
    end
    if (r_state == S_RUN) w_iw[17:2] = {uio_in, ui_in};
  end

`ifdef TT_MUX_CTRL_OWREG_EN
  logic [23:0] r_ow;

  always_ff @(posedge clk) begin
    if (rst) r_ow <= '0;
    else     r_ow <= w_ow_sel;
  end

  assign ow = r_ow;
`else
  assign ow = w_ow_sel;
`endif

  assign iw    = w_iw;
  assign ena   = r_ena;
  assign addr  = r_addr;
  assign state = r_state;
  assign busy  = r_busy;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Table-driven scoreboard bench for tt_mux_ctrl (default build: NUM_PROJ=4, RST_CYCLES=8, combinational ow).
module tb_tt_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0, sel_rst = 1'b0, sel_inc = 1'b0, sel_go = 1'b0;
  logic [7:0]  ui_in = '0, uio_in = '0;
  logic        proj_clk = 1'b0;
  logic [95:0] ow_bus = '0;
  logic [17:0] iw;
  logic [3:0]  ena;
  logic [23:0] ow;
  logic [1:0]  addr;
  logic [1:0]  state;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst, sr, si, sg, pclk;
    logic [7:0]  ui, uio;
    logic [95:0] owb;
    logic [1:0]  st;
    logic [1:0]  a;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  tt_mux_ctrl #(.NUM_PROJ(4), .ADDR_W(2), .RST_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .sel_rst(sel_rst), .sel_inc(sel_inc), .sel_go(sel_go),
    .ui_in(ui_in), .uio_in(uio_in), .proj_clk(proj_clk), .ow_bus(ow_bus),
    .iw(iw), .ena(ena), .ow(ow), .addr(addr), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input logic r, input logic sr, input logic si, input logic sg,
                     input logic [1:0] st, input logic [1:0] a);
    vec_t v;
    v.rst = r; v.sr = sr; v.si = si; v.sg = sg;
    v.pclk = 1'($urandom);
    v.ui   = 8'($urandom);
    v.uio  = 8'($urandom);
    v.owb  = {$urandom, $urandom, $urandom};
    v.st   = st;
    v.a    = a;
    tbl.push_back(v);
  endtask

  task automatic hold(input int n, input logic [1:0] st, input logic [1:0] a);
    for (int i = 0; i < n; i++) row(1'b0, 1'b0, 1'b0, 1'b0, st, a);
  endtask

  // Entered on a falling edge: drive, push expectation, then compare on the next falling edge.
  task automatic run_vec(input vec_t v);
    vec_t        e;
    logic [3:0]  e_ena;
    logic [17:0] e_iw;
    logic [23:0] e_ow;
    rst = v.rst; sel_rst = v.sr; sel_inc = v.si; sel_go = v.sg;
    ui_in = v.ui; uio_in = v.uio; proj_clk = v.pclk; ow_bus = v.owb;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    e_ena = (e.st != 2'd0) ? 4'(1 << e.a) : 4'd0;
    e_iw  = (e.st == 2'd2) ? {e.uio, e.ui, 1'b1, e.pclk} :
            (e.st == 2'd1) ? {16'd0, 1'b0, e.pclk} : 18'd0;
    e_ow  = (e.st != 2'd0) ? e.owb[24*e.a +: 24] : 24'd0;
    check("state", 32'(state), 32'(e.st));
    check("addr",  32'(addr),  32'(e.a));
    check("ena",   32'(ena),   32'(e_ena));
    check("busy",  32'(busy),  32'(e.st == 2'd1));
    check("iw",    32'(iw),    32'(e_iw));
    check("ow",    32'(ow),    32'(e_ow));
    check("ena_onehot0", 32'($onehot0(ena)), 32'd1);
  endtask

  task automatic run_table();
    foreach (tbl[i]) run_vec(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    @(negedge clk);

    // Reset, then sel_go: 8 cycles of RESET on project 0, then RUN.
    row(1, 0, 0, 0, 2'd0, 2'd0); row(1, 0, 0, 0, 2'd0, 2'd0); row(0, 0, 0, 0, 2'd0, 2'd0);
    row(0, 0, 0, 1, 2'd1, 2'd0); hold(7, 2'd1, 2'd0); hold(2, 2'd2, 2'd0);
    // sel_go in RUN is ignored.
    row(0, 0, 0, 1, 2'd2, 2'd0); hold(1, 2'd2, 2'd0);
    // Advance to 1, then 2, each with a full reset.
    row(0, 0, 1, 0, 2'd1, 2'd1); hold(7, 2'd1, 2'd1); row(0, 0, 0, 0, 2'd2, 2'd1);
    row(0, 0, 1, 0, 2'd1, 2'd2); hold(7, 2'd1, 2'd2); hold(2, 2'd2, 2'd2);
    // sel_rst beats sel_inc; sel_rst beats sel_go.
    row(0, 1, 1, 0, 2'd0, 2'd0);
    row(0, 1, 0, 1, 2'd0, 2'd0); row(0, 0, 0, 0, 2'd0, 2'd0);
    // sel_inc beats sel_go; sel_inc mid-RESET reloads the counter.
    row(0, 0, 1, 1, 2'd1, 2'd1); row(0, 0, 1, 0, 2'd1, 2'd2); row(0, 0, 1, 0, 2'd1, 2'd3);
    hold(7, 2'd1, 2'd3); row(0, 0, 0, 0, 2'd2, 2'd3);
    // Wrap 3 -> 0 from RUN.
    row(0, 0, 1, 0, 2'd1, 2'd0); hold(7, 2'd1, 2'd0); row(0, 0, 0, 0, 2'd2, 2'd0);
    // rst three cycles into RESET, rst swallowing sel_go, then a full restart.
    row(0, 1, 0, 0, 2'd0, 2'd0);
    row(0, 0, 0, 1, 2'd1, 2'd0); hold(2, 2'd1, 2'd0); row(1, 0, 0, 0, 2'd0, 2'd0);
    row(1, 0, 0, 1, 2'd0, 2'd0); row(0, 0, 0, 0, 2'd0, 2'd0);
    row(0, 0, 0, 1, 2'd1, 2'd0); hold(7, 2'd1, 2'd0); row(0, 0, 0, 0, 2'd2, 2'd0);
    // rst mid-RUN.
    row(1, 0, 0, 0, 2'd0, 2'd0); row(0, 0, 0, 0, 2'd0, 2'd0);
    run_table();

    // Hand sequence: RUN on project 2 with a known slice pattern on ow_bus.
    row(0, 0, 1, 0, 2'd1, 2'd1); row(0, 0, 1, 0, 2'd1, 2'd2); hold(7, 2'd1, 2'd2);
    row(0, 0, 0, 0, 2'd2, 2'd2);
    row(0, 0, 0, 0, 2'd2, 2'd2);
    tbl[tbl.size()-1].owb = {24'hFFFFFF, 24'hA5C33C, 24'hFFFFFF, 24'hFFFFFF};
    run_table();
    check("ow_sel2", 32'(ow), 32'h00A5C33C);

    // Hand sequence: sel_rst + sel_inc together from RUN addr 2.
    row(0, 1, 1, 0, 2'd0, 2'd0);
    run_table();
    check("ow_idle", 32'(ow), 32'd0);
    check("ena_idle", 32'(ena), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
